// File: rtl/data_mem_responder.sv
// data_mem_responder: data-memory responder behind the MEM stage.
// Accepts one load/store at a time, answers after LATENCY cycles with
// RV32I byte/half/word sizing and sign/zero extension.
// Optional feature macro: MISALIGN_TRAP_EN (reject misaligned half/word
// accesses instead of silently aligning them down).

module data_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);
    localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        cnt;
    logic [3:0]        cnt_next;

    logic              lat_write;
    logic [2:0]        lat_func3;
    logic [31:0]       lat_addr;
    logic [31:0]       lat_wdata;

    logic              accept;
    logic              complete;
    logic              func3_ok;
    logic              range_ok;
    logic              align_ok;
    logic              access_ok;
    logic [1:0]        lane;
    logic [IDX_W-1:0]  word_idx;
    logic [31:0]       mem_word;
    logic [31:0]       shifted;
    logic [31:0]       load_data;
    logic [31:0]       store_data;
    logic [3:0]        store_be;
    logic              mem_we;

    logic [31:0]       mem [DEPTH];

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && (state == IDLE);
    assign complete  = (state == WAIT) && (cnt == 4'd0);
    assign word_idx  = lat_addr[IDX_W+1:2];
    assign mem_word  = mem[word_idx];
    assign mem_we    = complete && lat_write && access_ok;

    // Decode the latched request: legality, lane selection, load extension and store lane enables.
    always_comb begin
        func3_ok   = 1'b0;
        range_ok   = (lat_addr < ADDR_LIMIT);
        align_ok   = 1'b1;
        lane       = lat_addr[1:0];
        shifted    = 32'd0;
        load_data  = 32'd0;
        store_data = 32'd0;
        store_be   = 4'b0000;

        if (lat_write) begin
            func3_ok = (lat_func3 inside {3'd0, 3'd1, 3'd2});
        end else begin
            func3_ok = (lat_func3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        end

`ifdef MISALIGN_TRAP_EN
        case (lat_func3[1:0])
            2'd1:    align_ok = (lat_addr[0] == 1'b0);
            2'd2:    align_ok = (lat_addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
`else
        case (lat_func3[1:0])
            2'd1:    lane = {lat_addr[1], 1'b0};
            2'd2:    lane = 2'b00;
            default: lane = lat_addr[1:0];
        endcase
`endif

        access_ok = func3_ok && range_ok && align_ok;

        shifted = mem_word >> {lane, 3'b000};
        case (lat_func3)
            3'd0:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'd1:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'd2:    load_data = mem_word;
            3'd4:    load_data = {24'd0, shifted[7:0]};
            3'd5:    load_data = {16'd0, shifted[15:0]};
            default: load_data = 32'd0;
        endcase

        store_data = lat_wdata << {lane, 3'b000};
        case (lat_func3[1:0])
            2'd0:    store_be = 4'b0001 << lane;
            2'd1:    store_be = 4'b0011 << lane;
            2'd2:    store_be = 4'b1111;
            default: store_be = 4'b0000;
        endcase
    end

    // Next-state and latency counter: IDLE accepts, WAIT counts down, RESP waits for the handshake.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = WAIT;
                    cnt_next   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // State, request capture and response registers; reset drops any in-flight request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_write <= 1'b0;
            lat_func3 <= 3'd0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                lat_write <= req_write;
                lat_func3 <= req_func3;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end
            if (complete) begin
                rsp_rdata <= (!lat_write && access_ok) ? load_data : 32'd0;
                rsp_err   <= !access_ok;
            end
        end
    end

    // Storage array with per-lane writes; deliberately not reset so contents survive a reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && store_be[i]) begin
                mem[word_idx][8*i +: 8] <= store_data[8*i +: 8];
            end
        end
    end

endmodule
